// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED blink sequencer.
package led_seq_pkg;

    localparam int unsigned CNT_W            = 4;
    localparam int unsigned DEF_N_REQ        = 4;
    localparam int unsigned DEF_TICK_DIV     = 12_500_000;
    localparam int unsigned DEF_ON_TICKS     = 2;
    localparam int unsigned DEF_OFF_TICKS    = 2;
    localparam int unsigned DEF_GAP_TICKS    = 8;
    localparam int unsigned DEF_HB_TICKS     = 4;

    typedef enum logic [1:0] {
        StIdle,
        StOn,
        StOff,
        StGap
    } state_t;

    // Bits needed to count 0 .. max_val-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

    function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                         input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Restartable clock divider: one-cycle tick every TICK_DIV cycles.
module led_tick_gen
    import led_seq_pkg::*;
#(
    parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic i_restart,
    output logic o_tick
);

    localparam int unsigned DIV_W = cnt_width(TICK_DIV);

    logic [DIV_W-1:0] r_div;
    logic             w_wrap;

    assign w_wrap = (r_div == DIV_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst || i_restart) begin
            r_div <= '0;
        end else if (w_wrap) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // A restart cycle never reports a tick so the new phase gets a full period.
    assign o_tick = w_wrap && !i_restart;

endmodule

// File: rtl/led_seq_ctrl.sv
// Shared-LED blink sequencer with fixed-priority arbitration.
// Optional idle heartbeat enabled by defining LED_SEQ_HEARTBEAT_EN.
module led_seq_ctrl
    import led_seq_pkg::*;
#(
    parameter int unsigned N_REQ     = DEF_N_REQ,
    parameter int unsigned TICK_DIV  = DEF_TICK_DIV,
    parameter int unsigned ON_TICKS  = DEF_ON_TICKS,
    parameter int unsigned OFF_TICKS = DEF_OFF_TICKS,
    parameter int unsigned GAP_TICKS = DEF_GAP_TICKS,
    parameter int unsigned HB_TICKS  = DEF_HB_TICKS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [CNT_W*N_REQ-1:0]   cnt,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic                     led
);

    localparam int unsigned PH_MAX = max4(ON_TICKS, OFF_TICKS, GAP_TICKS, HB_TICKS);
    localparam int unsigned PH_W   = cnt_width(PH_MAX);

    state_t            r_state, w_state_nxt;
    logic [N_REQ-1:0]  r_owner, w_owner_nxt;
    logic [N_REQ-1:0]  r_gnt,   w_gnt_nxt;
    logic [N_REQ-1:0]  r_done,  w_done_nxt;
    logic [CNT_W-1:0]  r_rem,   w_rem_nxt;
    logic [PH_W-1:0]   r_phase, w_phase_nxt;
    logic              r_led,   w_led_nxt;

    logic              w_tick;
    logic              w_restart;
    logic [N_REQ-1:0]  w_win_oh;
    logic [CNT_W-1:0]  w_win_cnt;

    // Descending scan so the lowest asserted index is the last to assign.
    always_comb begin
        w_win_oh  = '0;
        w_win_cnt = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_win_oh    = '0;
                w_win_oh[i] = 1'b1;
                w_win_cnt   = cnt[i*CNT_W +: CNT_W];
            end
        end
    end

    assign w_restart = (r_state == StIdle) && (req != '0);

    led_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk       (clk),
        .rst       (rst),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_rem_nxt   = r_rem;
        w_phase_nxt = r_phase;
        w_led_nxt   = r_led;
        w_gnt_nxt   = '0;
        w_done_nxt  = '0;

        unique case (r_state)
            StIdle: begin
                if (req != '0) begin
                    w_gnt_nxt   = w_win_oh;
                    w_owner_nxt = w_win_oh;
                    w_rem_nxt   = w_win_cnt;
                    w_phase_nxt = '0;
                    if (w_win_cnt == '0) begin
                        w_state_nxt = StGap;
                        w_led_nxt   = 1'b0;
                    end else begin
                        w_state_nxt = StOn;
                        w_led_nxt   = 1'b1;
                    end
                end else begin
`ifdef LED_SEQ_HEARTBEAT_EN
                    if (w_tick) begin
                        if (r_phase == PH_W'(HB_TICKS - 1)) begin
                            w_phase_nxt = '0;
                            w_led_nxt   = ~r_led;
                        end else begin
                            w_phase_nxt = r_phase + 1'b1;
                        end
                    end
`else
                    w_phase_nxt = '0;
                    w_led_nxt   = 1'b0;
`endif
                end
            end

            StOn: begin
                if (w_tick) begin
                    if (r_phase == PH_W'(ON_TICKS - 1)) begin
                        w_phase_nxt = '0;
                        w_state_nxt = StOff;
                        w_led_nxt   = 1'b0;
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end

            StOff: begin
                if (w_tick) begin
                    if (r_phase == PH_W'(OFF_TICKS - 1)) begin
                        w_phase_nxt = '0;
                        w_rem_nxt   = r_rem - 1'b1;
                        if (r_rem == CNT_W'(1)) begin
                            w_state_nxt = StGap;
                        end else begin
                            w_state_nxt = StOn;
                            w_led_nxt   = 1'b1;
                        end
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end

            StGap: begin
                if (w_tick) begin
                    if (r_phase == PH_W'(GAP_TICKS - 1)) begin
                        w_phase_nxt = '0;
                        w_done_nxt  = r_owner;
                        w_state_nxt = StIdle;
                        w_led_nxt   = 1'b0;
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = StIdle;
                w_led_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_owner <= '0;
            r_gnt   <= '0;
            r_done  <= '0;
            r_rem   <= '0;
            r_phase <= '0;
            r_led   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_gnt   <= w_gnt_nxt;
            r_done  <= w_done_nxt;
            r_rem   <= w_rem_nxt;
            r_phase <= w_phase_nxt;
            r_led   <= w_led_nxt;
        end
    end

    assign gnt  = r_gnt;
    assign done = r_done;
    assign led  = r_led;
    assign busy = (r_state != StIdle);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl with TICK_DIV=4 (ON/OFF 8 cycles, GAP 32, heartbeat 16).
module tb_led_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] cnt;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        led;

    int passed = 0;
    int total  = 0;

    logic       led_h  [0:127];
    logic       busy_h [0:127];
    logic [3:0] gnt_h  [0:127];
    logic [3:0] done_h [0:127];

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .N_REQ     (4),
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .OFF_TICKS (2),
        .GAP_TICKS (8),
        .HB_TICKS  (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .cnt  (cnt),
        .gnt  (gnt),
        .done (done),
        .busy (busy),
        .led  (led)
    );

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            led_h[k]  = led;
            busy_h[k] = busy;
            gnt_h[k]  = gnt;
            done_h[k] = done;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'hf;
        cnt = 16'h1111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (led !== 1'b0) $display("FAIL reset_led s%0d: got %b want 0", k, led);
            else passed++;
            total++; if (busy !== 1'b0) $display("FAIL reset_busy s%0d: got %b want 0", k, busy);
            else passed++;
            total++; if (gnt !== 4'b0) $display("FAIL reset_gnt s%0d: got %b want 0000", k, gnt);
            else passed++;
            total++; if (done !== 4'b0) $display("FAIL reset_done s%0d: got %b want 0000", k, done);
            else passed++;
            if (k == 1) begin
                rst = 1'b0;
                req = 4'b0;
            end
        end
    endtask

    task automatic test_single();
        int bad_led, bad_busy, gnt_n, done_n, pulses;
        logic exp_led;
        bad_led = 0; bad_busy = 0; gnt_n = 0; done_n = 0; pulses = 0;
        @(negedge clk);
        req = 4'b0010;
        cnt = 16'h0030;
        @(posedge clk); #1;
        req = 4'b0;
        cnt = 16'hffff;  // latched count must govern
        capture(90);
        for (int k = 0; k < 90; k++) begin
            exp_led = (k < 48) && ((k % 16) < 8);
            if (led_h[k] !== exp_led) bad_led++;
            if (busy_h[k] !== (k < 80)) bad_busy++;
            if (gnt_h[k] != 4'b0) gnt_n++;
            if (done_h[k] != 4'b0) done_n++;
            if (led_h[k] === 1'b1 && (k == 0 || led_h[k-1] === 1'b0)) pulses++;
        end
        total++; if (gnt_h[0] !== 4'b0010) $display("FAIL single_gnt: got %b want 0010", gnt_h[0]);
        else passed++;
        total++; if (gnt_n !== 1) $display("FAIL single_gnt_count: got %0d want 1", gnt_n);
        else passed++;
        total++; if (bad_led !== 0) $display("FAIL single_led_shape: got %0d bad want 0", bad_led);
        else passed++;
        total++; if (pulses !== 3) $display("FAIL single_pulses: got %0d want 3", pulses);
        else passed++;
        total++; if (bad_busy !== 0) $display("FAIL single_busy80: got %0d bad want 0", bad_busy);
        else passed++;
        total++; if (done_h[80] !== 4'b0010) $display("FAIL single_done: got %b want 0010", done_h[80]);
        else passed++;
        total++; if (done_n !== 1) $display("FAIL single_done_count: got %0d want 1", done_n);
        else passed++;
    endtask

    task automatic test_zero_count();
        int led_n, bad_busy, done_n;
        led_n = 0; bad_busy = 0; done_n = 0;
        @(negedge clk);
        req = 4'b0001;
        cnt = 16'h0000;
        @(posedge clk); #1;
        req = 4'b0;
        capture(40);
        for (int k = 0; k < 40; k++) begin
            if (led_h[k] !== 1'b0) led_n++;
            if (busy_h[k] !== (k < 32)) bad_busy++;
            if (done_h[k] != 4'b0) done_n++;
        end
        total++; if (gnt_h[0] !== 4'b0001) $display("FAIL zero_gnt: got %b want 0001", gnt_h[0]);
        else passed++;
        total++; if (led_n !== 0) $display("FAIL zero_led: got %0d high want 0", led_n);
        else passed++;
        total++; if (bad_busy !== 0) $display("FAIL zero_busy32: got %0d bad want 0", bad_busy);
        else passed++;
        total++; if (done_h[32] !== 4'b0001) $display("FAIL zero_done: got %b want 0001", done_h[32]);
        else passed++;
        total++; if (done_n !== 1) $display("FAIL zero_done_count: got %0d want 1", done_n);
        else passed++;
    endtask

    task automatic test_contention();
        int t, g_t, d_t;
        logic [3:0] exp;
        bit got;
        t = 0; d_t = 0;
        @(negedge clk);
        req = 4'hf;
        cnt = 16'h1111;
        for (int i = 0; i < 4; i++) begin
            exp = 4'b0001 << i;
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk); t++;
                if (gnt != 4'b0) got = 1'b1;
            end
            g_t = t;
            total++; if (gnt !== exp) $display("FAIL cont_gnt%0d: got %b want %b", i, gnt, exp);
            else passed++;
            if (i > 0) begin
                total++;
                if (g_t !== d_t + 1) $display("FAIL cont_gap%0d: got %0d want %0d", i, g_t, d_t + 1);
                else passed++;
            end
            req[i] = 1'b0;
            got = 1'b0;
            for (int k = 0; k < 100 && !got; k++) begin
                @(negedge clk); t++;
                if (done != 4'b0) got = 1'b1;
            end
            d_t = t;
            total++; if (done !== exp) $display("FAIL cont_done%0d: got %b want %b", i, done, exp);
            else passed++;
            total++;
            if (d_t - g_t !== 48) $display("FAIL cont_len%0d: got %0d want 48", i, d_t - g_t);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        int done_n, busy_n, gnt_n;
        done_n = 0; busy_n = 0; gnt_n = 0;
        @(negedge clk);
        req = 4'b0001;
        cnt = 16'h0003;
        @(posedge clk); #1;
        req = 4'b0;
        for (int k = 0; k <= 20; k++) @(negedge clk);
        total++;
        if ({led, busy} !== 2'b11) $display("FAIL mid_second_on: got %b want 11", {led, busy});
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        total++; if (led !== 1'b0) $display("FAIL mid_led: got %b want 0", led);
        else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy);
        else passed++;
        rst = 1'b0;
        capture(120);
        for (int k = 0; k < 120; k++) begin
            if (done_h[k] != 4'b0) done_n++;
            if (busy_h[k] !== 1'b0) busy_n++;
            if (gnt_h[k] != 4'b0) gnt_n++;
        end
        total++; if (done_n !== 0) $display("FAIL mid_no_done: got %0d want 0", done_n);
        else passed++;
        total++; if (busy_n !== 0) $display("FAIL mid_stay_idle: got %0d want 0", busy_n);
        else passed++;
        total++; if (gnt_n !== 0) $display("FAIL mid_no_gnt: got %0d want 0", gnt_n);
        else passed++;
    endtask

    task automatic test_heartbeat();
        int bad, toggles, exp_toggles;
        logic exp_led;
        bad = 0; toggles = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        capture(100);
        for (int k = 0; k < 100; k++) begin
`ifdef LED_SEQ_HEARTBEAT_EN
            exp_led = ((k / 16) % 2) == 1;
`else
            exp_led = 1'b0;
`endif
            if (led_h[k] !== exp_led) bad++;
            if (k > 0 && led_h[k] !== led_h[k-1]) toggles++;
        end
`ifdef LED_SEQ_HEARTBEAT_EN
        exp_toggles = 6;
`else
        exp_toggles = 0;
`endif
        total++; if (bad !== 0) $display("FAIL hb_pattern: got %0d bad want 0", bad);
        else passed++;
        total++;
        if (toggles !== exp_toggles) $display("FAIL hb_toggles: got %0d want %0d", toggles, exp_toggles);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_zero_count();
        test_contention();
        test_reset_mid();
        test_heartbeat();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have parameter N_REQ, default 4, number of requesters sharing the LED.
REQ-002 SHALL have parameter TICK_DIV, default 12_500_000, clk cycles per tick.
REQ-003 SHALL have parameters ON_TICKS=2, OFF_TICKS=2, GAP_TICKS=8 and HB_TICKS=4: phase lengths in ticks.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port req, input, N_REQ bits: level request per requester.
REQ-007 SHALL have port cnt, input, 4*N_REQ bits: packed blink count per requester, requester i in bits [4i+3:4i].
REQ-008 SHALL have port gnt, output, N_REQ bits: one-cycle one-hot grant pulse.
REQ-009 SHALL have port done, output, N_REQ bits: one-cycle one-hot completion pulse.
REQ-010 SHALL have port busy, output, 1 bit: high while a sequence is owned.
REQ-011 SHALL have port led, output, 1 bit: registered LED drive.

Function
REQ-012 SHALL implement states IDLE, ON, OFF, GAP.
REQ-013 SHALL arbitrate in IDLE only, fixed priority with the lowest asserted req index winning.
REQ-014 SHALL, on a clock edge in IDLE with req!=0, pulse gnt[w] next cycle, latch cnt[w] and owner w, restart the tick prescaler, and enter ON (or GAP if latched count=0) on that edge.
REQ-015 SHALL hold ON for ON_TICKS*TICK_DIV cycles with led=1, then enter OFF for OFF_TICKS*TICK_DIV cycles with led=0.
REQ-016 SHALL, at OFF end, decrement the remaining count; if nonzero it SHALL return to ON, otherwise enter GAP.
REQ-017 SHALL hold GAP for GAP_TICKS*TICK_DIV cycles with led=0, then pulse done[owner] for one cycle and return to IDLE on that edge.
REQ-018 SHALL not re-arbitrate on the done cycle; the earliest next gnt is the cycle after done.
REQ-019 SHALL ignore req and cnt changes while busy; latched values govern the sequence.
REQ-020 SHALL drive busy=1 in ON, OFF and GAP, and 0 in IDLE.
REQ-021 SHALL make total busy length cnt*(ON_TICKS+OFF_TICKS)*TICK_DIV + GAP_TICKS*TICK_DIV cycles.
REQ-022 SHALL treat count 0 as a GAP-only sequence with no LED pulses.
REQ-023 SHALL keep tick and phase counters wide enough for TICK_DIV-1 and max phase ticks, with no wrap inside a phase.

Reset
REQ-024 SHALL on rst=1 force state IDLE, led=0, busy=0, gnt=0, done=0, and clear counters and prescaler.
REQ-025 SHALL abort any sequence on mid-operation reset with no done pulse; rst has priority over all events.

Configuration
REQ-026 SHALL, with macro LED_SEQ_HEARTBEAT_EN defined, toggle led in IDLE every HB_TICKS*TICK_DIV cycles, starting from 0 after reset or sequence end.
REQ-027 SHALL, without LED_SEQ_HEARTBEAT_EN, hold led=0 in IDLE and omit heartbeat logic.

Structure
REQ-028 SHALL place the state typedef, CNT_W=4 and default parameter constants in package led_seq_pkg.
REQ-029 SHALL use one sub-module, led_tick_gen: a restartable TICK_DIV divider emitting a one-cycle tick.

Verification (TICK_DIV=4, so phase ON/OFF=8 cycles, GAP=32 cycles, heartbeat half-period=16 cycles)
REQ-030 SHALL cover reset: rst high 2 cycles with req=1111 -> led=0, busy=0, gnt=0, done=0 throughout and after.
REQ-031 SHALL cover single request: req=0010, cnt[7:4]=3 -> gnt=0010 for 1 cycle; exactly 3 led pulses of 8 cycles high and 8 low; busy high 80 cycles; done=0010 for 1 cycle.
REQ-032 SHALL cover contention: req=1111 held with all cnt=1 -> grants in order 0001, 0010, 0100, 1000; each gnt one cycle after the previous done.
REQ-033 SHALL cover reset mid-operation: rst 1 cycle during the second ON of a cnt=3 sequence -> next cycle led=0, busy=0, and no done pulse ever.
REQ-034 SHALL cover zero count: req=0001, cnt=0 -> gnt=0001; led stays 0; done=0001 after 32 busy cycles.
REQ-035 SHALL cover heartbeat config: idle 100 cycles -> with LED_SEQ_HEARTBEAT_EN led toggles every 16 cycles; without it led stays 0.
